// File: rtl/answer_pkg.sv
// Shared definitions for the contestant lock-in arbiter: phase codes, the
// arbiter FSM state encoding and the fixed-priority one-hot selector.
package answer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_READY = 3'b001;
  localparam logic [2:0] ST_GRAB  = 3'b010;

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_READY,
    FSM_GRAB,
    FSM_LOCKED,
    FSM_FOUL,
    FSM_TMO
  } fsm_t;

  // Isolates the lowest set bit, so contestant 0 always has the highest priority.
  function automatic logic [3:0] prio_sel(input logic [3:0] mask);
    prio_sel = mask & (~mask + 4'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Level debouncer for one synchronised button: dout follows din only after
// DEB_CYCLES consecutive samples that differ from the current dout.
module key_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [19:0] r_cnt;
  logic        r_dout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
    end else if (din == r_dout) begin
      r_cnt <= '0;
    end else if (r_cnt >= DEB_CYCLES - 20'd1) begin
      r_dout <= din;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 20'd1;
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/answer_lock.sv
// Contestant lock-in arbiter: decides first buzz, early-press foul or timeout
// per round. Define ANSWER_DEBOUNCE_EN to insert key_debounce on each button.
module answer_lock
  import answer_pkg::*;
#(
  parameter logic [31:0] WINDOW_CYCLES = 32'd150_000_000,
  parameter logic [19:0] DEB_CYCLES    = 20'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [3:0] btn,
  input  logic       host_clr,
  output logic [3:0] lock_people,
  output logic       isFoul,
  output logic [3:0] foul_people,
  output logic       timeout,
  output logic [3:0] banned
);

  localparam logic [31:0] CNT_LAST = WINDOW_CYCLES - 32'd1;

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_press_d;
  logic [3:0]  w_press_q;
  logic [3:0]  w_press_rise;
  logic [3:0]  w_elig_press;
  logic [3:0]  w_elig_rise;
  logic [2:0]  w_phase;

  fsm_t        r_fsm;
  fsm_t        w_fsm_next;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_next;
  logic [3:0]  r_lock_people;
  logic [3:0]  w_lock_next;
  logic [3:0]  r_foul_people;
  logic [3:0]  w_foul_next;
  logic        r_isfoul;
  logic        w_isfoul_next;
  logic        r_timeout;
  logic        w_timeout_next;
  logic [3:0]  r_banned;
  logic [3:0]  w_banned_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_press_d <= '0;
    end else begin
      r_sync1   <= btn;
      r_sync2   <= r_sync1;
      r_press_d <= w_press_q;
    end
  end

`ifdef ANSWER_DEBOUNCE_EN
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_deb
      key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (r_sync2[gi]),
        .dout (w_press_q[gi])
      );
    end
  endgenerate
`else
  logic w_unused_deb;
  assign w_unused_deb = ^DEB_CYCLES;
  assign w_press_q    = r_sync2;
`endif

  assign w_press_rise = w_press_q & ~r_press_d;
  assign w_elig_press = w_press_q & ~r_banned;
  assign w_elig_rise  = w_press_rise & ~r_banned;
  // Undefined phase codes collapse to idle so the FSM only ever sees three phases.
  assign w_phase = (state == ST_READY || state == ST_GRAB) ? state : ST_IDLE;

  always_comb begin
    w_fsm_next     = r_fsm;
    w_cnt_next     = r_cnt;
    w_lock_next    = r_lock_people;
    w_foul_next    = r_foul_people;
    w_isfoul_next  = r_isfoul;
    w_timeout_next = r_timeout;
    w_banned_next  = r_banned;
    case (r_fsm)
      FSM_IDLE: begin
        w_lock_next    = '0;
        w_foul_next    = '0;
        w_isfoul_next  = 1'b0;
        w_timeout_next = 1'b0;
        w_cnt_next     = '0;
        if (w_phase == ST_IDLE) w_banned_next = '0;
        if (w_phase == ST_READY)     w_fsm_next = FSM_READY;
        else if (w_phase == ST_GRAB) w_fsm_next = FSM_GRAB;
      end
      FSM_READY: begin
        w_cnt_next = '0;
        if (w_phase == ST_READY) begin
          if (|w_elig_press) begin
            w_fsm_next    = FSM_FOUL;
            w_foul_next   = prio_sel(w_elig_press);
            w_isfoul_next = 1'b1;
            w_banned_next = r_banned | prio_sel(w_elig_press);
          end
        end else if (w_phase == ST_GRAB) begin
          w_fsm_next = FSM_GRAB;
        end else begin
          w_fsm_next = FSM_IDLE;
        end
      end
      FSM_GRAB: begin
        // A lock beats expiry when both land on the same edge.
        if (w_phase != ST_GRAB) begin
          w_fsm_next = FSM_IDLE;
        end else if (|w_elig_rise) begin
          w_fsm_next  = FSM_LOCKED;
          w_lock_next = prio_sel(w_elig_rise);
        end else if (r_cnt >= CNT_LAST) begin
          w_fsm_next     = FSM_TMO;
          w_timeout_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      FSM_LOCKED: begin
        if (host_clr || w_phase != ST_GRAB) begin
          w_fsm_next  = FSM_IDLE;
          w_lock_next = '0;
        end
      end
      FSM_FOUL: begin
        if (host_clr || w_phase == ST_IDLE) begin
          w_fsm_next    = (host_clr && w_phase == ST_READY) ? FSM_READY : FSM_IDLE;
          w_isfoul_next = 1'b0;
          w_foul_next   = '0;
        end
      end
      FSM_TMO: begin
        if (host_clr || w_phase != ST_GRAB) begin
          w_fsm_next     = FSM_IDLE;
          w_timeout_next = 1'b0;
        end
      end
      default: begin
        w_fsm_next     = FSM_IDLE;
        w_lock_next    = '0;
        w_foul_next    = '0;
        w_isfoul_next  = 1'b0;
        w_timeout_next = 1'b0;
        w_cnt_next     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fsm         <= FSM_IDLE;
      r_cnt         <= '0;
      r_lock_people <= '0;
      r_foul_people <= '0;
      r_isfoul      <= 1'b0;
      r_timeout     <= 1'b0;
      r_banned      <= '0;
    end else begin
      r_fsm         <= w_fsm_next;
      r_cnt         <= w_cnt_next;
      r_lock_people <= w_lock_next;
      r_foul_people <= w_foul_next;
      r_isfoul      <= w_isfoul_next;
      r_timeout     <= w_timeout_next;
      r_banned      <= w_banned_next;
    end
  end

  assign lock_people = r_lock_people;
  assign isFoul      = r_isfoul;
  assign foul_people = r_foul_people;
  assign timeout     = r_timeout;
  assign banned      = r_banned;

endmodule

// File: tb/tb_answer_lock.sv
// Directed self-checking bench for answer_lock; inputs change and outputs are
// sampled on the falling clock edge.
module tb_answer_lock;

`ifdef ANSWER_DEBOUNCE_EN
  localparam int LAT = 6;
  localparam int WIN = 24;
`else
  localparam int LAT = 2;
  localparam int WIN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] state = 3'b000;
  logic [3:0] btn = 4'b0000;
  logic       host_clr = 1'b0;
  logic [3:0] lock_people;
  logic       isFoul;
  logic [3:0] foul_people;
  logic       timeout;
  logic [3:0] banned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  answer_lock #(
    .WINDOW_CYCLES(32'(WIN)),
    .DEB_CYCLES   (20'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .state       (state),
    .btn         (btn),
    .host_clr    (host_clr),
    .lock_people (lock_people),
    .isFoul      (isFoul),
    .foul_people (foul_people),
    .timeout     (timeout),
    .banned      (banned)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_gap();
    state = 3'b000; btn = 4'b0000; host_clr = 1'b0;
    step(10);
  endtask

  task automatic test_reset();
    rst = 1'b0; btn = 4'b1111; state = 3'b010;
    step(3);
    checks++; if (lock_people !== 4'b0000) begin errors++; $display("FAIL reset_lock got %b want 0000", lock_people); end
    checks++; if (isFoul !== 1'b0) begin errors++; $display("FAIL reset_isfoul got %b want 0", isFoul); end
    checks++; if (foul_people !== 4'b0000) begin errors++; $display("FAIL reset_foul got %b want 0000", foul_people); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    checks++; if (banned !== 4'b0000) begin errors++; $display("FAIL reset_banned got %b want 0000", banned); end
    btn = 4'b0000; state = 3'b000;
    rst = 1'b1;
    step(10);
    $display("[tb] reset: lock=%b foul=%b timeout=%b banned=%b", lock_people, foul_people, timeout, banned);
  endtask

  task automatic test_single_lock();
    state = 3'b010; btn = 4'b0100;
    step(LAT);
    checks++; if (lock_people !== 4'b0000) begin errors++; $display("FAIL single_early got %b want 0000", lock_people); end
    step(1);
    checks++; if (lock_people !== 4'b0100) begin errors++; $display("FAIL single_lock got %b want 0100", lock_people); end
    checks++; if (isFoul !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL single_flags got %b%b want 00", isFoul, timeout); end
    step(WIN + 2);
    checks++; if (lock_people !== 4'b0100 || timeout !== 1'b0) begin errors++; $display("FAIL single_hold got %b/%b want 0100/0", lock_people, timeout); end
    state = 3'b000;
    step(1);
    checks++; if (lock_people !== 4'b0000) begin errors++; $display("FAIL single_exit got %b want 0000", lock_people); end
    $display("[tb] single lock: lock=%b after phase exit", lock_people);
    idle_gap();
  endtask

  task automatic test_tie();
    state = 3'b010; btn = 4'b1010;
    step(LAT + 1);
    checks++; if (lock_people !== 4'b0010) begin errors++; $display("FAIL tie_lock got %b want 0010", lock_people); end
    btn = 4'b1011;
    step(LAT + 2);
    checks++; if (lock_people !== 4'b0010) begin errors++; $display("FAIL tie_later_rise got %b want 0010", lock_people); end
    host_clr = 1'b1;
    step(1);
    checks++; if (lock_people !== 4'b0000) begin errors++; $display("FAIL tie_host_clr got %b want 0000", lock_people); end
    $display("[tb] tie: lock cleared by host_clr, lock=%b", lock_people);
    idle_gap();
  endtask

  task automatic test_foul_ban();
    state = 3'b001;
    step(2);
    btn = 4'b1000;
    step(LAT + 1);
    checks++; if (isFoul !== 1'b1) begin errors++; $display("FAIL foul_isfoul got %b want 1", isFoul); end
    checks++; if (foul_people !== 4'b1000) begin errors++; $display("FAIL foul_people got %b want 1000", foul_people); end
    checks++; if (banned !== 4'b1000) begin errors++; $display("FAIL foul_banned got %b want 1000", banned); end
    checks++; if (lock_people !== 4'b0000) begin errors++; $display("FAIL foul_lock got %b want 0000", lock_people); end
    host_clr = 1'b1; btn = 4'b0000;
    step(1);
    host_clr = 1'b0;
    checks++; if (isFoul !== 1'b0 || foul_people !== 4'b0000) begin errors++; $display("FAIL foul_clear got %b/%b want 0/0000", isFoul, foul_people); end
    checks++; if (banned !== 4'b1000) begin errors++; $display("FAIL foul_ban_kept got %b want 1000", banned); end
    step(8);
    checks++; if (isFoul !== 1'b0) begin errors++; $display("FAIL foul_banned_no_refoul got %b want 0", isFoul); end
    state = 3'b010; btn = 4'b1000;
    step(LAT + 1);
    checks++; if (lock_people !== 4'b0000) begin errors++; $display("FAIL ban_no_lock got %b want 0000", lock_people); end
    btn = 4'b1001;
    step(LAT + 1);
    checks++; if (lock_people !== 4'b0001) begin errors++; $display("FAIL ban_other_lock got %b want 0001", lock_people); end
    state = 3'b000;
    step(2);
    checks++; if (banned !== 4'b0000 || lock_people !== 4'b0000) begin errors++; $display("FAIL ban_idle_clear got %b/%b want 0000/0000", banned, lock_people); end
    $display("[tb] foul/ban: banned=%b after idle", banned);
    idle_gap();
  endtask

  task automatic test_timeout();
    state = 3'b010;
    step(WIN);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got %b want 0", timeout); end
    step(1);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_assert got %b want 1", timeout); end
    checks++; if (lock_people !== 4'b0000 || isFoul !== 1'b0) begin errors++; $display("FAIL tmo_exclusive got %b/%b want 0000/0", lock_people, isFoul); end
    host_clr = 1'b1; state = 3'b000;
    step(1);
    host_clr = 1'b0;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b want 0", timeout); end
    step(3);
    // Rise reaches the FSM on exactly the expiry edge.
    state = 3'b010;
    step(WIN - LAT);
    btn = 4'b0001;
    step(LAT + 1);
    checks++; if (lock_people !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL tmo_race got %b/%b want 0001/0", lock_people, timeout); end
    $display("[tb] timeout: race resolved lock=%b timeout=%b", lock_people, timeout);
    idle_gap();
  endtask

  task automatic test_reset_mid_lock();
    state = 3'b010; btn = 4'b0001;
    step(LAT + 1);
    checks++; if (lock_people !== 4'b0001) begin errors++; $display("FAIL rst_mid_pre got %b want 0001", lock_people); end
    rst = 1'b0;
    step(1);
    rst = 1'b1; state = 3'b000;
    checks++; if (lock_people !== 4'b0000 || isFoul !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rst_mid_out got %b/%b/%b want 0000/0/0", lock_people, isFoul, timeout); end
    step(LAT + 2);
    checks++; if (lock_people !== 4'b0000) begin errors++; $display("FAIL rst_mid_idle got %b want 0000", lock_people); end
    $display("[tb] reset mid-lock: lock=%b", lock_people);
    idle_gap();
  endtask

`ifdef ANSWER_DEBOUNCE_EN
  task automatic test_debounce();
    state = 3'b010; btn = 4'b0001;
    step(3);
    btn = 4'b0000;
    step(4);
    checks++; if (lock_people !== 4'b0000) begin errors++; $display("FAIL deb_glitch got %b want 0000", lock_people); end
    state = 3'b000;
    step(3);
    state = 3'b010; btn = 4'b0001;
    step(LAT);
    checks++; if (lock_people !== 4'b0000) begin errors++; $display("FAIL deb_early got %b want 0000", lock_people); end
    step(1);
    checks++; if (lock_people !== 4'b0001) begin errors++; $display("FAIL deb_lock got %b want 0001", lock_people); end
    $display("[tb] debounce: lock=%b", lock_people);
    idle_gap();
  endtask
`endif

  initial begin
    test_reset();
    test_single_lock();
    test_tie();
    test_foul_ban();
    test_timeout();
    test_reset_mid_lock();
`ifdef ANSWER_DEBOUNCE_EN
    test_debounce();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/answer_lock.md
# answer_lock

Contestant lock-in arbiter for the answering machine. Samples the four contestant buttons against the controller's game-phase code and decides, per round, who buzzed first, who jumped the gun, or that nobody answered in time. Its `lock_people` and `isFoul` outputs feed the buzzer stage directly. That stage beeps on the 0→non-zero edge of `lock_people` and on `isFoul`, so both must be registered and glitch-free.

## Interface

Parameters:
- `WINDOW_CYCLES`, default 32'd150_000_000: length of the grab window in `clk` cycles before timeout (minimum 2).
- `DEB_CYCLES`, default 20'd1_000_000: stable-level cycles required by the debouncer (used only with `ANSWER_DEBOUNCE_EN`).

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: system clock; every register updates on its rising edge.
- `rst` input 1: synchronous active-low reset; sampled on `clk` rising edge only.
- `state` input 3: game-phase code from the top controller. 3'b000 is idle, 3'b001 is ready (question being read), 3'b010 is grab window; any other code is treated as idle.
- `btn` input 4: raw contestant buttons, active-high, asynchronous.
- `host_clr` input 1: host "next round" pulse, active-high, level-sampled.
- `lock_people` output 4: one-hot winning contestant; 0 when nobody is locked.
- `isFoul` output 1: high while a foul is latched.
- `foul_people` output 4: one-hot offender of the current foul.
- `timeout` output 1: high while the grab window has expired with no winner.
- `banned` output 4: contestants excluded from locking until the next idle phase.

## Operation

- **Input synchronisation:** `btn` passes through a 2-flop synchroniser giving `press_q[3:0]`. `press_rise` is `press_q & ~press_q_d`.
- **Priority:** bit 0 has the highest priority. On simultaneous rises, the lowest set index wins.
- **FSM states:** IDLE, READY, GRAB, LOCKED, FOUL, TMO.
- **IDLE:**
  - Clears all outputs and the window counter.
  - Clears `banned` whenever `state`==000.
  - Moves to READY on `state`==001 and to GRAB on `state`==010.
- **READY:**
  - Any `press_q` bit that is not banned → FOUL. `foul_people` is the priority-selected offender, `isFoul`=1, and that bit is ORed into `banned`.
  - `state`==010 → GRAB with the counter at 0.
  - Any other code → IDLE.
- **GRAB:**
  - The counter increments each cycle.
  - `press_rise & ~banned` non-zero → LOCKED, with `lock_people` set to the priority-selected bit.
  - The counter reaching `WINDOW_CYCLES`-1 with no eligible rise → TMO, `timeout`=1.
  - If a rise and expiry occur in the same cycle, the lock wins.
  - `state`≠010 → IDLE.
  - A button held continuously from READY into GRAB produces no rise, so it never locks.
- **LOCKED:** `lock_people` is held. `host_clr` or `state`≠010 → IDLE.
- **FOUL:**
  - `isFoul` and `foul_people` are held.
  - `host_clr` → READY if `state`==001, otherwise IDLE; `banned` is kept.
  - `state`==000 → IDLE.
- **TMO:** `timeout` is held. `host_clr` or `state`≠010 → IDLE.
- **Output invariant:** at most one of `lock_people`≠0, `isFoul`, `timeout` is non-zero in any cycle.
- **Counter width:** 32 bits, saturating at `WINDOW_CYCLES`-1; it never wraps.

## Timing

- **Reset:** `rst`=0 at a rising edge puts the FSM in IDLE with `lock_people`, `foul_people`, `banned`=0, `isFoul`, `timeout`=0, and synchroniser/debouncer state=0. This applies mid-round as well.
- **Latency without debounce:** a `btn` rise first sampled at edge N gives `lock_people` / `isFoul` valid after edge N+2.
- **Latency with debounce:** add `DEB_CYCLES` to the above.
- **Timeout:** `timeout` asserts after exactly `WINDOW_CYCLES` edges in GRAB.
- **Clear / phase exit:** `host_clr` or a phase exit drops the outputs after the next edge (1-cycle latency).
- **Outputs** are all registered; no combinational path from inputs to outputs.

## Configuration

- `ANSWER_DEBOUNCE_EN` defined: each synchronised button is filtered by `key_debounce`. The output changes only after `DEB_CYCLES` consecutive equal samples.
- `ANSWER_DEBOUNCE_EN` undefined: `press_q` is the raw 2-flop synchroniser output and `DEB_CYCLES` is ignored.

## Structure

- **Shared package `answer_pkg`:**
  - Phase codes `ST_IDLE`=3'b000, `ST_READY`=3'b001, `ST_GRAB`=3'b010.
  - The FSM state enum.
  - A priority-select function (4-bit mask → one-hot, bit 0 first).
- **Sub-module `key_debounce`:** one per button, with ports `clk`, `rst`, `din`, `dout`, parameter `DEB_CYCLES`. It is instantiated only under the macro.

## Test plan

1. **Single lock:** `state`=010, `btn`=4'b0100 rises at edge 10 → `lock_people`=4'b0100 after edge 12. `isFoul`=0 and `timeout`=0 throughout.
2. **Tie:** `btn`=4'b1010 rises in the same cycle during GRAB → `lock_people`=4'b0010. Later rises are ignored until `host_clr`.
3. **Foul then ban:**
   - `state`=001, `btn[3]` pressed → `isFoul`=1, `foul_people`=4'b1000, `banned`=4'b1000.
   - `host_clr` returns the block to READY.
   - `state`=010, `btn[3]` rises → no lock. `btn[0]` rises → `lock_people`=4'b0001.
4. **Timeout:** `WINDOW_CYCLES`=8, GRAB with no press → `timeout`=1 after edge 8. A rise at edge 8 instead gives a lock with `timeout`=0.
5. **Reset mid-lock:** LOCKED with `lock_people`=4'b0001, then `rst`=0 for 1 cycle → all outputs 0 after that edge and the FSM in IDLE.
6. **Debounce (macro defined, `DEB_CYCLES`=4):** a 3-cycle `btn` glitch produces no lock. A 6-cycle press locks after synchroniser latency plus 4 cycles.
